// File: rtl/rv_decode_queue_pkg.sv
// rv_decode_pkg: RV32I opcodes, funct7 constants and the decoded record shared by decoder and queue.
// Defining RV_DECODE_M_EXT_EN accepts the M-extension funct7 (0000001) as a legal R-type.
package rv_decode_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
`ifdef RV_DECODE_M_EXT_EN
    localparam bit M_EXT = 1'b1;
`else
    localparam bit M_EXT = 1'b0;
`endif
    // imm and pc are held at the widest supported XLEN and narrowed at the queue outputs
    localparam int XLEN_MAX = 64;
    typedef struct packed {
        logic                rd_e;
        logic                rs1_e;
        logic                rs2_e;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic                imm_e;
        logic [XLEN_MAX-1:0] imm;
        logic                pc_e;
        logic                jump_e;
        logic                branch_e;
        logic                illegal;
        logic [16:0]         full_inst;
        logic [XLEN_MAX-1:0] pc;
    } decoded_t;
endpackage

// File: rtl/rv_decode_queue_if.sv
// rv_decode_queue_if: fetch-side and execute-side handshakes of the decode queue.
interface rv_decode_queue_if #(parameter int XLEN = 32, parameter int CNT_W = 3);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic             rd_e, rs1_e, rs2_e;
    logic [4:0]       rd, rs1, rs2;
    logic             imm_e;
    logic [XLEN-1:0]  imm;
    logic             pc_e, jump_e, branch_e, illegal;
    logic [16:0]      full_inst;
    logic [XLEN-1:0]  pc_out;
    logic [CNT_W-1:0] count;
    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, rd_e, rs1_e, rs2_e, rd, rs1, rs2, imm_e, imm,
               pc_e, jump_e, branch_e, illegal, full_inst, pc_out, count
    );
    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, rd_e, rs1_e, rs2_e, rd, rs1, rs2, imm_e, imm,
               pc_e, jump_e, branch_e, illegal, full_inst, pc_out, count
    );
endinterface

// File: rtl/rv_decode_queue_comb.sv
// rv_decode_comb: combinational RV32I decode of one instruction into a decoded_t record.
// Register indices are reported only when their enable is set; illegal records carry just the pc.
module rv_decode_comb
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output decoded_t        d
);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic r_legal;
    logic [XLEN_MAX-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign op = inst[6:0];
    assign f3 = inst[14:12];
    assign f7 = inst[31:25];
    assign r_legal = f7 == F7_BASE || f7 == F7_ALT || (M_EXT && f7 == F7_MULDIV);
    assign imm_i = {{52{inst[31]}}, inst[31:20]};
    assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
    assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    always_comb begin
        d = '0;
        d.pc = XLEN_MAX'(pc);
        case (op)
            OP_R: begin
                {d.rd_e, d.rs1_e, d.rs2_e} = {3{r_legal}};
                d.illegal = !r_legal;
                d.full_inst = r_legal ? {f7, f3, op} : '0;
            end
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYS: begin
                {d.rd_e, d.rs1_e, d.imm_e} = 3'b111;
                d.jump_e = op == OP_JALR;
                d.imm = imm_i;
                d.full_inst = {7'b0, f3, op};
            end
            OP_STORE: begin
                {d.rs1_e, d.rs2_e} = 2'b11;
                d.imm = imm_s;
                d.full_inst = {7'b0, f3, op};
            end
            OP_BRANCH: begin
                {d.rs1_e, d.rs2_e, d.imm_e, d.pc_e, d.branch_e} = 5'b11111;
                d.imm = imm_b;
                d.full_inst = {7'b0, f3, op};
            end
            OP_LUI, OP_AUIPC: begin
                {d.rd_e, d.pc_e} = 2'b11;
                d.imm = imm_u;
                d.full_inst = {10'b0, op};
            end
            OP_JAL: begin
                {d.rd_e, d.imm_e, d.pc_e, d.jump_e} = 4'b1111;
                d.imm = imm_j;
                d.full_inst = {10'b0, op};
            end
            default: d.illegal = 1'b1;
        endcase
        d.rd  = d.rd_e  ? inst[11:7]  : '0;
        d.rs1 = d.rs1_e ? inst[19:15] : '0;
        d.rs2 = d.rs2_e ? inst[24:20] : '0;
    end
endmodule

// File: rtl/rv_decode_queue.sv
// rv_decode_queue: decodes fetched instructions and buffers the records in a DEPTH-entry FIFO for execute.
// RV_DECODE_M_EXT_EN (see rv_decode_pkg) makes MUL/DIV/REM legal; otherwise they are flagged illegal.
module rv_decode_queue
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic clk,
    input logic rst_n,
    rv_decode_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    decoded_t dec, head;
    decoded_t mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count;
    logic push, pop, in_ready, out_valid;
    rv_decode_comb #(.XLEN(XLEN)) u_dec (.inst(q.in_inst), .pc(q.in_pc), .d(dec));
    assign in_ready  = count != CNT_W'(DEPTH);
    assign out_valid = count != '0;
    assign push = q.in_valid && in_ready && !q.flush;
    assign pop  = out_valid && q.out_ready && !q.flush;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (q.flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop) rptr <= rptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= dec;
    end
    // an empty queue presents an all-zero record
    assign head = out_valid ? mem[rptr] : '0;
    assign q.in_ready  = in_ready;
    assign q.out_valid = out_valid;
    assign q.count     = count;
    assign q.rd_e      = head.rd_e;
    assign q.rs1_e     = head.rs1_e;
    assign q.rs2_e     = head.rs2_e;
    assign q.rd        = head.rd;
    assign q.rs1       = head.rs1;
    assign q.rs2       = head.rs2;
    assign q.imm_e     = head.imm_e;
    assign q.imm       = head.imm[XLEN-1:0];
    assign q.pc_e      = head.pc_e;
    assign q.jump_e    = head.jump_e;
    assign q.branch_e  = head.branch_e;
    assign q.illegal   = head.illegal;
    assign q.full_inst = head.full_inst;
    assign q.pc_out    = head.pc[XLEN-1:0];
    if (XLEN < XLEN_MAX) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{head.imm[XLEN_MAX-1:XLEN], head.pc[XLEN_MAX-1:XLEN]};
    end
endmodule

// File: tb/tb_rv_decode_queue.sv
// tb_rv_decode_queue: scoreboard bench; a format-table decode model predicts every record the queue presents.
module tb_rv_decode_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef RV_DECODE_M_EXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif
    typedef struct packed {
        logic rd_e, rs1_e, rs2_e;
        logic [4:0] rd, rs1, rs2;
        logic imm_e;
        logic [XLEN-1:0] imm;
        logic pc_e, jump_e, branch_e, illegal;
        logic [16:0] full_inst;
        logic [XLEN-1:0] pc;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv_decode_queue_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
    rv_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .q(bus)
    );

    rec_t sbq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_rec(input string name, input rec_t act, input rec_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: classify the opcode into an instruction format, then derive everything from the format.
    function automatic rec_t model(input logic [31:0] i, input logic [31:0] pc);
        rec_t e;
        byte f;
        logic [6:0] op, f7;
        logic [11:0] s12;
        logic [12:0] b13;
        logic [20:0] j21;
        op = i[6:0];
        f7 = i[31:25];
        case (op)
            7'h33: f = "R";
            7'h13, 7'h03, 7'h67, 7'h0f, 7'h73: f = "I";
            7'h23: f = "S";
            7'h63: f = "B";
            7'h37, 7'h17: f = "U";
            7'h6f: f = "J";
            default: f = "X";
        endcase
        if (f == "R" && !(f7 == 7'h00 || f7 == 7'h20 || (MEXT && f7 == 7'h01))) f = "X";
        e = '0;
        e.pc = pc;
        if (f == "X") begin
            e.illegal = 1'b1;
            return e;
        end
        e.rd_e  = f == "R" || f == "I" || f == "U" || f == "J";
        e.rs1_e = f == "R" || f == "I" || f == "S" || f == "B";
        e.rs2_e = f == "R" || f == "S" || f == "B";
        e.imm_e = f == "I" || f == "B" || f == "J";
        e.pc_e  = f == "B" || f == "U" || f == "J";
        e.jump_e = op == 7'h6f || op == 7'h67;
        e.branch_e = f == "B";
        e.rd  = e.rd_e  ? i[11:7]  : 5'd0;
        e.rs1 = e.rs1_e ? i[19:15] : 5'd0;
        e.rs2 = e.rs2_e ? i[24:20] : 5'd0;
        s12 = {i[31:25], i[11:7]};
        b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        case (f)
            "I": e.imm = XLEN'($signed(i[31:20]));
            "S": e.imm = XLEN'($signed(s12));
            "B": e.imm = XLEN'($signed(b13));
            "U": e.imm = {i[31:12], 12'b0};
            "J": e.imm = XLEN'($signed(j21));
            default: e.imm = '0;
        endcase
        if (f == "R") e.full_inst = {f7, i[14:12], op};
        else if (f == "U" || f == "J") e.full_inst = {10'b0, op};
        else e.full_inst = {7'b0, i[14:12], op};
        return e;
    endfunction

    function automatic rec_t actual();
        rec_t a;
        a.rd_e = bus.rd_e; a.rs1_e = bus.rs1_e; a.rs2_e = bus.rs2_e;
        a.rd = bus.rd; a.rs1 = bus.rs1; a.rs2 = bus.rs2;
        a.imm_e = bus.imm_e; a.imm = bus.imm;
        a.pc_e = bus.pc_e; a.jump_e = bus.jump_e; a.branch_e = bus.branch_e;
        a.illegal = bus.illegal; a.full_inst = bus.full_inst; a.pc = bus.pc_out;
        return a;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r, inst;
        logic [6:0] op;
        int k;
        r = $urandom();
        k = $urandom_range(0, 14);
        case (k)
            0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h67;
            4: op = 7'h0f; 5: op = 7'h73; 6: op = 7'h23; 7: op = 7'h63;
            8: op = 7'h37; 9: op = 7'h17; 10: op = 7'h6f; 11: op = 7'h33;
            default: op = r[6:0];
        endcase
        inst = {r[31:7], op};
        if (op == 7'h33) begin
            k = $urandom_range(0, 3);
            inst[31:25] = k == 0 ? 7'h00 : k == 1 ? 7'h20 : k == 2 ? 7'h01 : r[31:25];
        end
        return inst;
    endfunction

    // Monitor: at each falling edge compares the presented head and occupancy against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("count", 64'(bus.count), 64'(sbq.size()));
                chk("out_valid", 64'(bus.out_valid), 64'(sbq.size() != 0));
                chk("in_ready", 64'(bus.in_ready), 64'(sbq.size() != DEPTH));
                if (sbq.size() != 0) begin
                    cmp_rec("head", actual(), sbq[0]);
                    if (bus.out_valid && bus.out_ready) void'(sbq.pop_front());
                end else begin
                    cmp_rec("empty_out", actual(), '0);
                end
            end
        end
    end

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic acc;
        bus.in_valid = v; bus.in_inst = inst; bus.in_pc = pc;
        bus.out_ready = ordy; bus.flush = fl;
        @(negedge clk);
        acc = v && bus.in_ready && !fl;
        @(posedge clk);
        if (fl) sbq.delete();
        else if (acc) sbq.push_back(model(inst, pc));
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && sbq.size() != 0; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic push_rand(input logic ordy);
        logic [31:0] pc;
        pc = $urandom() & 32'hFFFF_FFFC;
        step(1'b1, gen_inst(), pc, ordy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
        bus.out_ready = 1'b0; bus.flush = 1'b0;
        #12;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        cmp_rec("rst_out", actual(), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        step(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
        chk("addi_valid", 64'(bus.out_valid), 64'd1);
        chk("addi_rd", 64'(bus.rd), 64'd1);
        chk("addi_rs1", 64'(bus.rs1), 64'd0);
        chk("addi_imm", 64'(bus.imm), 64'd5);
        chk("addi_imm_e", 64'(bus.imm_e), 64'd1);
        chk("addi_pc", 64'(bus.pc_out), 64'h100);
        chk("addi_illegal", 64'(bus.illegal), 64'd0);
        drain();

        repeat (DEPTH) push_rand(1'b0);
        chk("full_count", 64'(bus.count), 64'(DEPTH));
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        push_rand(1'b0);
        chk("refused_count", 64'(bus.count), 64'(DEPTH));
        push_rand(1'b1);
        chk("full_pushpop_count", 64'(bus.count), 64'(DEPTH - 1));
        push_rand(1'b1);
        chk("pushpop_count", 64'(bus.count), 64'(DEPTH - 1));
        drain();

        step(1'b1, 32'hFE00_0EE3, 32'h200, 1'b0, 1'b0);
        chk("beq_branch_e", 64'(bus.branch_e), 64'd1);
        chk("beq_pc_e", 64'(bus.pc_e), 64'd1);
        chk("beq_imm", 64'(bus.imm), 64'hFFFF_FFFC);
        drain();

        step(1'b1, 32'h0220_8033, 32'h300, 1'b0, 1'b0);
        chk("mul_illegal", 64'(bus.illegal), 64'(!MEXT));
        chk("mul_full_inst", 64'(bus.full_inst), MEXT ? 64'h0_0033 | (64'h1 << 10) : 64'h0);
        drain();

        push_rand(1'b0);
        push_rand(1'b0);
        step(1'b1, 32'h0050_0093, 32'h400, 1'b0, 1'b1);
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("flush_nostore", 64'(bus.count), 64'd0);

        repeat (3) push_rand(1'b0);
        #2 rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        cmp_rec("arst_out", actual(), '0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc;
            pc = $urandom() & 32'hFFFF_FFFC;
            step($urandom_range(0, 9) < 7, gen_inst(), pc,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
        end
        drain();
        chk("final_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
